dest_reg_hazard_pipe: RTL
=========================

Name: dest_reg_hazard_pipe

Overview:
- Sits directly downstream of the 5-bit 3:1 write-register select mux in the EX stage.
- Consumes the selected destination register (rt / rd / 31), the RegWrite control and the MemRead control, and carries them through the MEM and WB stages.
- Compares them against source registers to drive the EX-stage forwarding muxes and the ID-stage load-use stall.
- Maintains a saturating stall-cycle performance counter.

Parameters:
- ADDR_W, 5, register-number width.
- CNT_W, 16, stall counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- ex_wr_reg  in  ADDR_W  destination register from the write-register select mux.
- ex_reg_write  in  1  EX-stage RegWrite.
- ex_mem_read  in  1  EX-stage MemRead (load).
- ex_flush  in  1  squash the current EX instruction (branch/jump taken).
- ex_rs  in  ADDR_W  EX-stage rs.
- ex_rt  in  ADDR_W  EX-stage rt.
- id_rs  in  ADDR_W  ID-stage rs.
- id_rt  in  ADDR_W  ID-stage rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- cnt_clear  in  1  synchronous clear of stall counter.
- fwd_a  out  2  ALU operand A select: 00 regfile, 01 WB, 10 MEM.
- fwd_b  out  2  same encoding, operand B.
- stall_id  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- mem_wr_reg  out  ADDR_W  MEM-stage destination.
- mem_reg_write  out  1  MEM-stage RegWrite.
- wb_wr_reg  out  ADDR_W  WB-stage destination.
- wb_reg_write  out  1  WB-stage RegWrite to register file.
- stall_count  out  CNT_W  stall cycles since reset/clear.

Behaviour:
- Reset (Reset_n=0, asynchronous, any time including mid-stall):
  - All MEM/WB stage registers and stall_count go to 0 immediately.
  - Consequently fwd_a = fwd_b = 00 and stall_id = 0, unless driven by EX/ID inputs per the rules below.
- Effective EX write: ex_we = ex_reg_write & ~ex_flush & (ex_wr_reg != 0). Writes to $0 are never tracked.
- Each rising edge:
  - MEM <= {ex_wr_reg, ex_we, ex_mem_read & ~ex_flush}.
  - WB <= {mem_wr_reg, mem_reg_write}.
  - No stall input: the pipeline always advances. A stall is realised upstream as a bubble (ex_reg_write=0) entering EX.
- Latency: a destination register presented in EX at cycle N appears on mem_* at N+1 and on wb_* at N+2.
- Forwarding (combinational), per operand, using src = ex_rs for A and ex_rt for B:
  - 10 if mem_reg_write & ~mem_mem_read & mem_wr_reg == src.
  - else 01 if wb_reg_write & wb_wr_reg == src.
  - else 00.
  - MEM has priority over WB when both match.
  - src == 0 always yields 00.
- Load-use stall (combinational):
  - stall_id = ex_mem_read & ex_we & ((id_uses_rs & id_rs == ex_wr_reg) | (id_uses_rt & id_rt == ex_wr_reg)).
  - Flush dominates: if ex_flush = 1, stall_id = 0.
  - A load in MEM never forwards. After the one-cycle stall the load is in WB and forwards via 01.
- stall_count:
  - On each edge: if cnt_clear, count <= 0.
  - Else if stall_id and count != all-ones, count <= count + 1.
  - Saturates at 2^CNT_W - 1.
  - Clear takes priority over increment in the same cycle.
- Back-to-back writes to the same register: the newer one (MEM) wins the forward.

Test Plan:
- Reset: Reset_n low mid-run with mem_reg_write=1 -> all mem_*/wb_* and stall_count read 0 within the same cycle; fwd_a = fwd_b = 00.
- ALU chain: EX add writes $8; next cycle ex_rs=8 -> fwd_a=10; following cycle with ex_rt=8 -> fwd_b=01; wb_wr_reg=8 and wb_reg_write=1 at N+2.
- Load-use: ex_mem_read=1, ex_wr_reg=9, id_rt=9, id_uses_rt=1 -> stall_id=1, stall_count 0->1; after bubble and advance, consumer in EX gets fwd_b=01, never 10.
- $0 and flush: ex_wr_reg=0 with ex_reg_write=1 -> mem_reg_write=0, no forward. A load with ex_flush=1 and a matching id_rs -> stall_id=0 and the MEM entry is a bubble.
- Priority: MEM and WB both hold $10, ex_rs=10 -> fwd_a=10.
- Counter: CNT_W=2, hold a load-use stall for 5 cycles -> count saturates at 3. Assert cnt_clear together with stall_id -> count becomes 0.

Source files
------------

// File: rtl/dest_reg_hazard_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dest_reg_hazard_pipe
// Description : Carries the EX destination register through MEM/WB and derives
//               EX forwarding selects, ID load-use stall and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_reg_hazard_pipe #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ex_wr_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_flush,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              cnt_clear,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_id,
    output logic [ADDR_W-1:0] mem_wr_reg,
    output logic              mem_reg_write,
    output logic [ADDR_W-1:0] wb_wr_reg,
    output logic              wb_reg_write,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] c_FWD_RF  = 2'b00;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    logic [ADDR_W-1:0] r_mem_wr_reg;
    logic              r_mem_reg_write;
    logic              r_mem_mem_read;
    logic [ADDR_W-1:0] r_wb_wr_reg;
    logic              r_wb_reg_write;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_ex_we;
    logic              w_id_hit;
    logic              w_stall;

    // Writes to $0 and squashed instructions are never tracked downstream.
    assign w_ex_we = ex_reg_write & ~ex_flush & (ex_wr_reg != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_mem_wr_reg    <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_wr_reg     <= '0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_mem_wr_reg    <= ex_wr_reg;
            r_mem_reg_write <= w_ex_we;
            r_mem_mem_read  <= ex_mem_read & ~ex_flush;
            r_wb_wr_reg     <= r_mem_wr_reg;
            r_wb_reg_write  <= r_mem_reg_write;
        end
    end

    function automatic logic [1:0] f_fwd_sel(input logic [ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (src != '0) begin
            // A load result is not available in MEM; it can only come from WB.
            if (r_mem_reg_write && !r_mem_mem_read && (r_mem_wr_reg == src))
                sel = c_FWD_MEM;
            else if (r_wb_reg_write && (r_wb_wr_reg == src))
                sel = c_FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = f_fwd_sel(ex_rs);
        fwd_b = f_fwd_sel(ex_rt);
    end

    assign w_id_hit = (id_uses_rs & (id_rs == ex_wr_reg)) |
                      (id_uses_rt & (id_rt == ex_wr_reg));
    assign w_stall  = ex_mem_read & w_ex_we & w_id_hit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_stall_count <= '0;
        else if (cnt_clear)
            r_stall_count <= '0;
        else if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign stall_id      = w_stall;
    assign mem_wr_reg    = r_mem_wr_reg;
    assign mem_reg_write = r_mem_reg_write;
    assign wb_wr_reg     = r_wb_wr_reg;
    assign wb_reg_write  = r_wb_reg_write;
    assign stall_count   = r_stall_count;

endmodule
`default_nettype wire
